sram_result_writer: RTL

Writer-side counterpart of the ANN SRAM read path. After the network finishes classifying an image, this block accepts the stream of 16-bit output scores from the processing datapath and packs them two per 32-bit word. It writes the packed words to consecutive SRAM word addresses starting at a supplied base, holding each write until the SRAM acknowledges it. It reports completion, or a timeout error, back to the top-level controller.

---
 rtl/sram_result_writer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sram_result_writer.sv
// Packs 16-bit ANN output scores two per 32-bit word and writes them to
// consecutive SRAM word addresses, holding each write until it is acknowledged.
module sram_result_writer #(
    parameter int NUM_RESULTS = 10,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_address,
    input  logic              result_valid,
    input  logic [15:0]       result_data,
    output logic              result_ready,
    input  logic              write_ack,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       write_data,
    output logic              write,
    output logic              busy,
    output logic              w_done,
    output logic              w_error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam logic [6:0] NUM_C    = 7'(NUM_RESULTS);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [6:0]  count;
    logic [7:0]  timer;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD_LO;
            LOAD_LO: begin
                if (result_valid) begin
                    state_nxt = ((count + 7'd1) == NUM_C) ? WRITE : LOAD_HI;
                end
            end
            LOAD_HI: if (result_valid) state_nxt = WRITE;
            WRITE: begin
                // An acknowledge on the final timer cycle still wins over the timeout
                if (write_ack) begin
                    state_nxt = (count == NUM_C) ? DONE : LOAD_LO;
                end else if (timer == TMO_LAST) begin
                    state_nxt = ERROR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            address    <= '0;
            write_data <= '0;
            count      <= '0;
            timer      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        address <= start_address;
                        count   <= '0;
                        timer   <= '0;
                    end
                end
                LOAD_LO: begin
                    if (result_valid) begin
                        write_data <= {16'h0000, result_data};
                        count      <= count + 7'd1;
                    end
                end
                LOAD_HI: begin
                    if (result_valid) begin
                        write_data[31:16] <= result_data;
                        count             <= count + 7'd1;
                    end
                end
                WRITE: begin
                    if (write_ack) begin
                        timer <= '0;
                        if (count != NUM_C) address <= address + ADDR_W'(1);
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        result_ready = (state == LOAD_LO) || (state == LOAD_HI);
        write        = (state == WRITE);
        busy         = (state != IDLE);
        w_done       = (state == DONE);
        w_error      = (state == ERROR);
    end

endmodule
